id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS core; sits directly upstream of the ALU (arith and logic units).
- Captures decoded operands and control, applies EX-stage operand forwarding from EX/MEM and MEM/WB, and presents final ALU operands A/B and 4-bit func.
- Detects load-use hazards and inserts bubbles; honours the global stall and the branch flush.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register address width
FUNC_W, 4, ALU function code width

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
stall  input  1  global stall (memory wait); hold stage
flush  input  1  branch/jump flush; insert bubble
id_valid  input  1  ID holds a real instruction
id_rs_data  input  DATA_W  register-file rs value
id_rt_data  input  DATA_W  register-file rt value
id_rs_addr  input  REG_AW  rs index
id_rt_addr  input  REG_AW  rt index
id_rd_addr  input  REG_AW  destination index (already rt/rd selected)
id_imm  input  DATA_W  sign/zero-extended immediate
id_alu_src  input  1  1 = B operand from immediate
id_func  input  FUNC_W  ALU function code
id_reg_write  input  1  writes register file
id_mem_read  input  1  load
id_mem_write  input  1  store
id_mem_to_reg  input  1  writeback from memory
mem_reg_write  input  1  EX/MEM stage writes a register
mem_rd_addr  input  REG_AW  EX/MEM destination
mem_result  input  DATA_W  EX/MEM ALU result
wb_reg_write  input  1  MEM/WB stage writes a register
wb_rd_addr  input  REG_AW  MEM/WB destination
wb_result  input  DATA_W  MEM/WB writeback value
hazard_stall  output  1  load-use hazard; freeze PC and IF/ID
ex_valid  output  1  EX holds a real instruction
ex_a  output  DATA_W  ALU operand A (forwarded rs)
ex_b  output  DATA_W  ALU operand B (imm or forwarded rt)
ex_store_data  output  DATA_W  forwarded rt, for stores
ex_func  output  FUNC_W  ALU function code
ex_rd_addr  output  REG_AW  destination index
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  output  1 each  registered control

Behaviour:
- Reset (async, rst high): all registered state 0. ex_valid=0, all control 0, ex_func=0, addresses 0, ex_a=ex_b=ex_store_data=0, hazard_stall=0.
- hazard_stall is combinational: ex_mem_read_q & ex_valid_q & (ex_rd_q != 0) & (ex_rd_q == id_rs_addr | ex_rd_q == id_rt_addr).
- Update priority on each rising edge: stall > (flush | hazard_stall) > capture.
  - stall=1: control, addresses, imm and func hold. rs_q and rt_q reload with their current forwarded values, so a producer that retires during the stall is not lost.
  - flush=1 or hazard_stall=1 (stall=0): bubble. valid, reg_write, mem_read, mem_write and mem_to_reg go to 0. Data and address registers are don't-care; they are loaded with 0.
  - Otherwise: capture all id_* inputs. Latency is 1 cycle from ID to ex_*.
- Forwarding (combinational on registered state), per operand (rs_q, rt_q):
  - If mem_reg_write, mem_rd_addr != 0 and mem_rd_addr == the operand's address, use mem_result.
  - Else if the same conditions hold for wb, use wb_result.
  - Else use the registered value.
  - EX/MEM takes priority over MEM/WB. Register 0 is never forwarded.
- ex_a = fwd(rs). ex_store_data = fwd(rt). ex_b = alu_src_q ? imm_q : fwd(rt).
- Forwarding is applied regardless of ex_valid; downstream gates on ex_valid.
- Control outputs are driven directly from registers, with no combinational path from id_*.
- Reset mid-operation: asynchronous clear on assertion; first capture occurs on the first rising edge after deassertion.

Optional Feature:
- Macro ID_EX_FWD_EN.
- Defined: forwarding as described above.
- Undefined: forwarding muxes removed. ex_a = rs_q, ex_store_data = rt_q, ex_b = alu_src_q ? imm_q : rt_q. mem_*/wb_* inputs are ignored. Load-use detection and the stall refresh are unchanged (the refresh reloads raw values).

Test Plan:
- Reset: assert rst mid-cycle with ex_valid=1 -> all outputs 0 immediately; release, then id_rs_data=0x0000_00F0, id_rt_data=0x0000_000F, func=4'b1110 -> next edge ex_a=0xF0, ex_b=0x0F, ex_func=0xE, ex_valid=1.
- EX/MEM priority: ex rs=5, mem_rd=5 with mem_result=0x1111_1111, wb_rd=5 with wb_result=0x2222_2222 -> ex_a=0x1111_1111. Drop mem_reg_write -> ex_a=0x2222_2222. Set rd=0 -> no forwarding.
- Immediate select: alu_src=1, imm=0xFFFF_FFFC, rt forwarded 0x55 -> ex_b=0xFFFF_FFFC, ex_store_data=0x55.
- Load-use: EX holds lw with rd=8; ID rs=8 -> hazard_stall=1; next edge ex_valid=0 and all control 0. The following cycle the instruction is captured, with forwarding from MEM/WB giving the load value.
- Stall refresh: stall=1 for 3 cycles while wb_rd matches rt with wb_result=0xDEAD_BEEF for the first cycle only -> ex_store_data stays 0xDEAD_BEEF through the stall; control held.
- Flush vs stall: flush=1 and stall=1 together -> stage holds (stall wins). flush=1 alone -> bubble; ex_valid=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// +-------------------------------------------------------------------------+
// | id_ex_stage: ID/EX pipeline register with load-use detection and       |
// | EX-stage operand forwarding (forwarding muxes built when ID_EX_FWD_EN). |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int FUNC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_alu_src,
  input  logic [FUNC_W-1:0] id_func,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [DATA_W-1:0] wb_result,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [FUNC_W-1:0] ex_func,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg
);

  logic              valid_q,      valid_d;
  logic [DATA_W-1:0] rs_q,         rs_d;
  logic [DATA_W-1:0] rt_q,         rt_d;
  logic [DATA_W-1:0] imm_q,        imm_d;
  logic [REG_AW-1:0] rs_addr_q,    rs_addr_d;
  logic [REG_AW-1:0] rt_addr_q,    rt_addr_d;
  logic [REG_AW-1:0] rd_q,         rd_d;
  logic              alu_src_q,    alu_src_d;
  logic [FUNC_W-1:0] func_q,       func_d;
  logic              reg_write_q,  reg_write_d;
  logic              mem_read_q,   mem_read_d;
  logic              mem_write_q,  mem_write_d;
  logic              mem_to_reg_q, mem_to_reg_d;

  logic [DATA_W-1:0] w_fwd_rs;
  logic [DATA_W-1:0] w_fwd_rt;

`ifdef ID_EX_FWD_EN
  // EX/MEM is younger than MEM/WB, so it wins; r0 is hard-wired and never forwarded.
  always_comb begin
    w_fwd_rs = rs_q;
    w_fwd_rt = rt_q;
    if (mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == rs_addr_q))
      w_fwd_rs = mem_result;
    else if (wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == rs_addr_q))
      w_fwd_rs = wb_result;
    if (mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == rt_addr_q))
      w_fwd_rt = mem_result;
    else if (wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == rt_addr_q))
      w_fwd_rt = wb_result;
  end
`else
  logic w_unused;
  assign w_unused = ^{mem_reg_write, mem_rd_addr, mem_result,
                      wb_reg_write, wb_rd_addr, wb_result, rs_addr_q, rt_addr_q};
  assign w_fwd_rs = rs_q;
  assign w_fwd_rt = rt_q;
`endif

  assign hazard_stall = mem_read_q & valid_q & (rd_q != '0) &
                        ((rd_q == id_rs_addr) | (rd_q == id_rt_addr));

  always_comb begin
    valid_d      = valid_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    imm_d        = imm_q;
    rs_addr_d    = rs_addr_q;
    rt_addr_d    = rt_addr_q;
    rd_d         = rd_q;
    alu_src_d    = alu_src_q;
    func_d       = func_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    if (stall) begin
      // Refresh operands so a producer retiring during the stall is captured.
      rs_d = w_fwd_rs;
      rt_d = w_fwd_rt;
    end else if (flush || hazard_stall) begin
      valid_d      = 1'b0;
      rs_d         = '0;
      rt_d         = '0;
      imm_d        = '0;
      rs_addr_d    = '0;
      rt_addr_d    = '0;
      rd_d         = '0;
      alu_src_d    = 1'b0;
      func_d       = '0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
    end else begin
      valid_d      = id_valid;
      rs_d         = id_rs_data;
      rt_d         = id_rt_data;
      imm_d        = id_imm;
      rs_addr_d    = id_rs_addr;
      rt_addr_d    = id_rt_addr;
      rd_d         = id_rd_addr;
      alu_src_d    = id_alu_src;
      func_d       = id_func;
      reg_write_d  = id_reg_write;
      mem_read_d   = id_mem_read;
      mem_write_d  = id_mem_write;
      mem_to_reg_d = id_mem_to_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      rs_q         <= '0;
      rt_q         <= '0;
      imm_q        <= '0;
      rs_addr_q    <= '0;
      rt_addr_q    <= '0;
      rd_q         <= '0;
      alu_src_q    <= 1'b0;
      func_q       <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      imm_q        <= imm_d;
      rs_addr_q    <= rs_addr_d;
      rt_addr_q    <= rt_addr_d;
      rd_q         <= rd_d;
      alu_src_q    <= alu_src_d;
      func_q       <= func_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_a          = w_fwd_rs;
  assign ex_b          = alu_src_q ? imm_q : w_fwd_rt;
  assign ex_store_data = w_fwd_rt;
  assign ex_func       = func_q;
  assign ex_rd_addr    = rd_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_mem_to_reg = mem_to_reg_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// +-------------------------------------------------------------------------+
// | tb_id_ex_stage: directed self-checking bench for id_ex_stage.           |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic        id_alu_src;
  logic [3:0]  id_func;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic [31:0] mem_result, wb_result;
  logic        hazard_stall, ex_valid;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [3:0]  ex_func;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .FUNC_W(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_rs_addr(id_rs_addr),
    .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_func(id_func), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
    .ex_store_data(ex_store_data), .ex_func(ex_func), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rsa, input logic [31:0] rsd,
                        input logic [4:0] rta, input logic [31:0] rtd, input logic [4:0] rda,
                        input logic src, input logic [31:0] imm, input logic [3:0] fn,
                        input logic rw, input logic mr, input logic mw, input logic m2r);
    id_valid = v;   id_rs_addr = rsa; id_rs_data = rsd; id_rt_addr = rta;
    id_rt_data = rtd; id_rd_addr = rda; id_alu_src = src; id_imm = imm; id_func = fn;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_id(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_reg_write = 1'b0; mem_rd_addr = 5'd0; mem_result = 32'h0;
    wb_reg_write  = 1'b0; wb_rd_addr  = 5'd0; wb_result  = 32'h0;
    #2;
    chk("reset_valid",  32'(ex_valid), 32'h0);
    chk("reset_a",      ex_a, 32'h0);
    chk("reset_ctrl",   32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}), 32'h0);
    chk("reset_hazard", 32'(hazard_stall), 32'h0);

    // Reset asserted mid-cycle while EX holds a valid instruction
    @(negedge clk);
    rst = 1'b0;
    set_id(1'b1, 5'd1, 32'h77, 5'd2, 32'h66, 5'd3, 1'b0, 32'h0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("pre_rst_valid", 32'(ex_valid), 32'h1);
    chk("pre_rst_a",     ex_a, 32'h77);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(ex_valid), 32'h0);
    chk("async_rst_a",     ex_a, 32'h0);
    chk("async_rst_func",  32'(ex_func), 32'h0);
    chk("async_rst_rw",    32'(ex_reg_write), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    set_id(1'b1, 5'd1, 32'h0000_00F0, 5'd2, 32'h0000_000F, 5'd3, 1'b0, 32'h0, 4'b1110,
           1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("cap_a",     ex_a, 32'h0000_00F0);
    chk("cap_b",     ex_b, 32'h0000_000F);
    chk("cap_func",  32'(ex_func), 32'hE);
    chk("cap_valid", 32'(ex_valid), 32'h1);
    chk("cap_rd",    32'(ex_rd_addr), 32'd3);

    // Forwarding priority on rs=5
    set_id(1'b1, 5'd5, 32'hAAAA_0005, 5'd6, 32'h66, 5'd10, 1'b0, 32'h0, 4'h2,
           1'b1, 1'b0, 1'b0, 1'b0);
    step();
    mem_reg_write = 1'b1; mem_rd_addr = 5'd5; mem_result = 32'h1111_1111;
    wb_reg_write  = 1'b1; wb_rd_addr  = 5'd5; wb_result  = 32'h2222_2222;
    #1;
    chk("fwd_mem_prio", ex_a, FWD ? 32'h1111_1111 : 32'hAAAA_0005);
    chk("fwd_rt_none",  ex_store_data, 32'h66);
    mem_reg_write = 1'b0;
    #1;
    chk("fwd_wb", ex_a, FWD ? 32'h2222_2222 : 32'hAAAA_0005);
    mem_reg_write = 1'b1; mem_rd_addr = 5'd0; wb_rd_addr = 5'd0;
    #1;
    chk("fwd_r0_blocked", ex_a, 32'hAAAA_0005);
    mem_reg_write = 1'b0; wb_reg_write = 1'b0;

    // Immediate select while rt is forwarded
    set_id(1'b1, 5'd1, 32'h1, 5'd7, 32'h12, 5'd11, 1'b1, 32'hFFFF_FFFC, 4'h0,
           1'b1, 1'b0, 1'b0, 1'b0);
    step();
    wb_reg_write = 1'b1; wb_rd_addr = 5'd7; wb_result = 32'h55;
    #1;
    chk("imm_b",      ex_b, 32'hFFFF_FFFC);
    chk("imm_store",  ex_store_data, FWD ? 32'h55 : 32'h12);
    wb_reg_write = 1'b0; wb_rd_addr = 5'd0; wb_result = 32'h0;

    // Load-use hazard: lw r8 in EX, consumer reads r8
    set_id(1'b1, 5'd1, 32'h100, 5'd2, 32'h0, 5'd8, 1'b1, 32'h4, 4'h0,
           1'b1, 1'b1, 1'b0, 1'b1);
    step();
    chk("lw_mem_read", 32'(ex_mem_read), 32'h1);
    set_id(1'b1, 5'd8, 32'h0000_0BAD, 5'd3, 32'h33, 5'd9, 1'b0, 32'h0, 4'h1,
           1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("lu_hazard", 32'(hazard_stall), 32'h1);
    step();
    chk("lu_bubble_valid", 32'(ex_valid), 32'h0);
    chk("lu_bubble_ctrl",  32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}), 32'h0);
    chk("lu_hazard_clr",   32'(hazard_stall), 32'h0);
    step();
    wb_reg_write = 1'b1; wb_rd_addr = 5'd8; wb_result = 32'h1234_5678;
    #1;
    chk("lu_cap_valid", 32'(ex_valid), 32'h1);
    chk("lu_cap_rd",    32'(ex_rd_addr), 32'd9);
    chk("lu_cap_a",     ex_a, FWD ? 32'h1234_5678 : 32'h0000_0BAD);
    wb_reg_write = 1'b0; wb_rd_addr = 5'd0; wb_result = 32'h0;

    // Stall refresh: store with rt=4; producer visible on WB only during first stalled edge
    set_id(1'b1, 5'd0, 32'h0, 5'd4, 32'h0000_1111, 5'd0, 1'b1, 32'h8, 4'h0,
           1'b0, 1'b0, 1'b1, 1'b0);
    step();
    stall = 1'b1;
    wb_reg_write = 1'b1; wb_rd_addr = 5'd4; wb_result = 32'hDEAD_BEEF;
    set_id(1'b0, 5'd1, 32'h9, 5'd2, 32'h9999, 5'd12, 1'b0, 32'h0, 4'h7,
           1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("stall_pre", ex_store_data, FWD ? 32'hDEAD_BEEF : 32'h0000_1111);
    step();
    wb_reg_write = 1'b0; wb_rd_addr = 5'd0; wb_result = 32'h0;
    #1;
    chk("stall1_store", ex_store_data, FWD ? 32'hDEAD_BEEF : 32'h0000_1111);
    chk("stall1_mw",    32'(ex_mem_write), 32'h1);
    step();
    chk("stall2_store", ex_store_data, FWD ? 32'hDEAD_BEEF : 32'h0000_1111);
    chk("stall2_valid", 32'(ex_valid), 32'h1);
    step();
    chk("stall3_store", ex_store_data, FWD ? 32'hDEAD_BEEF : 32'h0000_1111);
    chk("stall3_func",  32'(ex_func), 32'h0);
    chk("stall3_b",     ex_b, 32'h8);

    // Flush with stall holds; flush alone bubbles
    flush = 1'b1;
    step();
    chk("flush_stall_valid", 32'(ex_valid), 32'h1);
    chk("flush_stall_mw",    32'(ex_mem_write), 32'h1);
    stall = 1'b0;
    step();
    chk("flush_valid", 32'(ex_valid), 32'h0);
    chk("flush_ctrl",  32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}), 32'h0);
    flush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
